// File: rtl/csr_counter_file_if.sv
// CSR access bus between the X stage (master) and csr_counter_file (slave).
// Read data and the illegal flag return one cycle after the strobe.
interface csr_counter_file_if #(parameter int DWIDTH = 32);
  logic              csr_we;
  logic              csr_re;
  logic [1:0]        csr_op;
  logic [11:0]       csr_addr;
  logic [DWIDTH-1:0] csr_wdata;
  logic [DWIDTH-1:0] csr_rdata;
  logic              csr_illegal;

  modport master (output csr_we, csr_re, csr_op, csr_addr, csr_wdata,
                  input  csr_rdata, csr_illegal);
  modport slave  (input  csr_we, csr_re, csr_op, csr_addr, csr_wdata,
                  output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_counter_file.sv
// tohost, mcountinhibit, cycle/instret counters and optional event counters.
// Define CSR_HPM_EN to build the NUM_EVT hpmcounters and their inhibit bits.
module csr_counter_file #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  csr_counter_file_if.slave   csr,
  input  logic                retire,
  input  logic                stall,
  input  logic [NUM_EVT-1:0]  event_i,
  input  logic                ctr_clear,
  output logic [DWIDTH-1:0]   tohost,
  output logic                tohost_valid
);
  localparam logic [11:0] A_TOHOST = 12'h51E;
  localparam logic [11:0] A_INH    = 12'h320;
  localparam logic [11:0] A_CYC    = 12'hC00;
  localparam logic [11:0] A_INS    = 12'hC02;
  localparam logic [11:0] A_EVT    = 12'hC03;
  localparam logic [11:0] HI       = 12'h080;
  localparam bit          HAS_HI   = CNT_WIDTH > DWIDTH;

  function automatic logic [DWIDTH-1:0] inh_mask();
    logic [DWIDTH-1:0] m;
    m    = '0;
    m[0] = 1'b1;
    m[2] = 1'b1;
`ifdef CSR_HPM_EN
    for (int i = 0; i < NUM_EVT; i++) m[3+i] = 1'b1;
`endif
    return m;
  endfunction

  localparam logic [DWIDTH-1:0] INH_MASK = inh_mask();

  // Shift rather than slice so CNT_WIDTH == DWIDTH elaborates to zero.
  function automatic logic [DWIDTH-1:0] hi_half(input logic [CNT_WIDTH-1:0] v);
    return DWIDTH'(v >> DWIDTH);
  endfunction

  logic [CNT_WIDTH-1:0] cycle_q, instret_q;
  logic [DWIDTH-1:0]    inhibit;
`ifdef CSR_HPM_EN
  logic [NUM_EVT-1:0][CNT_WIDTH-1:0] evt_q;
`else
  wire unused_evt = ^event_i;
`endif

  logic              mapped, ro, do_wr, wr_ok, illegal_n;
  logic [DWIDTH-1:0] old, wval;

  always_comb begin
    mapped = 1'b0;
    ro     = 1'b1;
    old    = '0;
    case (csr.csr_addr)
      A_TOHOST: begin mapped = 1'b1; ro = 1'b0; old = tohost; end
      A_INH:    begin mapped = 1'b1; ro = 1'b0; old = inhibit; end
      A_CYC:    begin mapped = 1'b1; old = cycle_q[DWIDTH-1:0]; end
      A_CYC | HI: begin mapped = HAS_HI; old = hi_half(cycle_q); end
      A_INS:    begin mapped = 1'b1; old = instret_q[DWIDTH-1:0]; end
      A_INS | HI: begin mapped = HAS_HI; old = hi_half(instret_q); end
      default: ;
    endcase
    // Event addresses stay mapped (reading 0) when the counters are not built.
    for (int i = 0; i < NUM_EVT; i++) begin
      if (csr.csr_addr == A_EVT + 12'(i)) begin
        mapped = 1'b1;
`ifdef CSR_HPM_EN
        old = evt_q[i][DWIDTH-1:0];
`endif
      end
      if (HAS_HI && csr.csr_addr == (A_EVT | HI) + 12'(i)) begin
        mapped = 1'b1;
`ifdef CSR_HPM_EN
        old = hi_half(evt_q[i]);
`endif
      end
    end

    case (csr.csr_op)
      2'b01:   wval = csr.csr_wdata;
      2'b10:   wval = old | csr.csr_wdata;
      2'b11:   wval = old & ~csr.csr_wdata;
      default: wval = old;
    endcase
    // RS/RC with a zero mask is a pure read.
    do_wr     = csr.csr_we && csr.csr_op != 2'b00 &&
                !(csr.csr_op[1] && csr.csr_wdata == '0);
    wr_ok     = do_wr && mapped && !ro;
    illegal_n = ((csr.csr_we || csr.csr_re) && !mapped) || (do_wr && mapped && ro);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tohost          <= '0;
      tohost_valid    <= 1'b0;
      inhibit         <= '0;
      csr.csr_rdata   <= '0;
      csr.csr_illegal <= 1'b0;
      cycle_q         <= '0;
      instret_q       <= '0;
    end else begin
      tohost_valid    <= 1'b0;
      csr.csr_illegal <= illegal_n;
      if (csr.csr_we || csr.csr_re) csr.csr_rdata <= old;
      if (wr_ok && csr.csr_addr == A_TOHOST) begin
        tohost       <= wval;
        tohost_valid <= 1'b1;
      end
      if (wr_ok && csr.csr_addr == A_INH) inhibit <= wval & INH_MASK;

      if (ctr_clear)       cycle_q <= '0;
      else if (!inhibit[0]) cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (ctr_clear)                            instret_q <= '0;
      else if (retire && !stall && !inhibit[2]) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

`ifdef CSR_HPM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_EVT; i++) begin
        if (ctr_clear)                                 evt_q[i] <= '0;
        else if (event_i[i] && !stall && !inhibit[3+i]) evt_q[i] <= evt_q[i] + CNT_WIDTH'(1);
      end
    end
  end
`endif
endmodule

// File: tb/tb_csr_counter_file.sv
// Directed bench for csr_counter_file: a vector table for CSR access behaviour
// plus hand sequences for counter wrap, stall, clear, inhibit and async reset.
module tb_csr_counter_file;
  logic       clk = 1'b0;
  logic       reset;
  logic       retire, stall, ctr_clear;
  logic [3:0] event_i;
  logic [31:0] tohost;
  logic        tohost_valid;
  int tests = 0;
  int fails = 0;

  csr_counter_file_if #(.DWIDTH(32)) bus ();

  csr_counter_file #(.DWIDTH(32), .CNT_WIDTH(64), .NUM_EVT(4)) dut (
    .clk(clk), .reset(reset), .csr(bus), .retire(retire), .stall(stall),
    .event_i(event_i), .ctr_clear(ctr_clear), .tohost(tohost),
    .tohost_valid(tohost_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ck_rd;
    logic [31:0] rd;
    logic        ill;
    logic [31:0] th;
    logic        vld;
  } vec_t;

`ifdef CSR_HPM_EN
  localparam logic [31:0] INH_ALL = 32'h7D;
`else
  localparam logic [31:0] INH_ALL = 32'h5;
`endif

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] wdata);
    bus.csr_we = we; bus.csr_re = re; bus.csr_op = op;
    bus.csr_addr = addr; bus.csr_wdata = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
  endtask

  initial begin
    //           we    re    op     addr     wdata         ck    rd            ill   tohost  vld
    tbl[0]  = '{1'b1, 1'b0, 2'b01, 12'h51E, 32'h1,        1'b1, 32'h0,        1'b0, 32'h1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'b10, 12'h51E, 32'h0,        1'b1, 32'h1,        1'b0, 32'h1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b00, 12'h51E, 32'h0,        1'b1, 32'h1,        1'b0, 32'h1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'b10, 12'h51E, 32'h6,        1'b1, 32'h1,        1'b0, 32'h7, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 2'b11, 12'h51E, 32'h3,        1'b1, 32'h7,        1'b0, 32'h4, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0,        1'b1, 32'h7,        1'b0, 32'h4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'b00, 12'h123, 32'h0,        1'b1, 32'h0,        1'b1, 32'h4, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'b01, 12'hC00, 32'h5,        1'b0, 32'h0,        1'b1, 32'h4, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'b11, 12'hC00, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'b00, 12'hC83, 32'h0,        1'b1, 32'h0,        1'b0, 32'h4, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'b00, 12'hC03, 32'h0,        1'b1, 32'h0,        1'b0, 32'h4, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'b01, 12'h320, 32'hFFFF_FFFF, 1'b1, 32'h0,       1'b0, 32'h4, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'b00, 12'h320, 32'h0,        1'b1, INH_ALL,      1'b0, 32'h4, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'b01, 12'h320, 32'h0,        1'b1, INH_ALL,      1'b0, 32'h4, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'b00, 12'h320, 32'h0,        1'b1, 32'h0,        1'b0, 32'h4, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 2'b00, 12'hC80, 32'h0,        1'b1, 32'h0,        1'b0, 32'h4, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 2'b00, 12'h51E, 32'h0,        1'b1, 32'h4,        1'b0, 32'h4, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 2'b00, 12'h51E, 32'h9,        1'b1, 32'h4,        1'b0, 32'h4, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 2'b00, 12'hFFF, 32'h0,        1'b1, 32'h0,        1'b1, 32'h4, 1'b0};

    reset = 1'b1; retire = 1'b0; stall = 1'b0; ctr_clear = 1'b0; event_i = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("reset rdata", bus.csr_rdata, 32'h0);
    chk("reset illegal", {31'b0, bus.csr_illegal}, 32'h0);
    chk("reset tohost", tohost, 32'h0);
    chk("reset tohost_valid", {31'b0, tohost_valid}, 32'h0);
    reset = 1'b0;

    // 10 idle cycles then read cycle low
    repeat (10) @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 12'hC00, 32'h0);
    @(negedge clk);
    chk("cycle after 10", bus.csr_rdata, 32'd10);
    chk("idle tohost", tohost, 32'h0);
    chk("idle tohost_valid", {31'b0, tohost_valid}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].op, tbl[i].addr, tbl[i].wdata);
      @(negedge clk);
      if (tbl[i].ck_rd) chk($sformatf("vec%0d rdata", i), bus.csr_rdata, tbl[i].rd);
      chk($sformatf("vec%0d illegal", i), {31'b0, bus.csr_illegal}, {31'b0, tbl[i].ill});
      chk($sformatf("vec%0d tohost", i), tohost, tbl[i].th);
      chk($sformatf("vec%0d valid", i), {31'b0, tohost_valid}, {31'b0, tbl[i].vld});
    end
    idle();

    // 32-bit boundary carry into the high half
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_q;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 12'hC00, 32'h0);
    @(negedge clk);
    chk("wrap cycle lo", bus.csr_rdata, 32'h0);
    drive(1'b0, 1'b1, 2'b00, 12'hC80, 32'h0);
    @(negedge clk);
    chk("wrap cycle hi", bus.csr_rdata, 32'h1);
    idle();

    // retire 5 cycles, stalled on 2
    ctr_clear = 1'b1;
    @(negedge clk);
    ctr_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      retire = 1'b1;
      stall  = (k == 1 || k == 3);
      @(negedge clk);
    end
    retire = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 12'hC02, 32'h0);
    @(negedge clk);
    chk("instret stall", bus.csr_rdata, 32'd3);

    // clear beats a coincident increment, then counting continues
    idle();
    retire = 1'b1; ctr_clear = 1'b1;
    @(negedge clk);
    ctr_clear = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 12'hC02, 32'h0);
    @(negedge clk);
    chk("instret cleared", bus.csr_rdata, 32'd0);
    retire = 1'b0;
    @(negedge clk);
    chk("instret resumes", bus.csr_rdata, 32'd1);

    // inhibit instret; the write edge still counts with the old inhibit
    drive(1'b1, 1'b0, 2'b01, 12'h320, 32'h4);
    retire = 1'b1;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    retire = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 12'hC02, 32'h0);
    @(negedge clk);
    chk("instret inhibited", bus.csr_rdata, 32'd2);
    drive(1'b1, 1'b0, 2'b01, 12'hC02, 32'h55);
    @(negedge clk);
    chk("ro write illegal", {31'b0, bus.csr_illegal}, 32'h1);
    chk("ro write rdata", bus.csr_rdata, 32'd2);
    drive(1'b0, 1'b1, 2'b00, 12'hC02, 32'h0);
    @(negedge clk);
    chk("ro write no change", bus.csr_rdata, 32'd2);
    chk("ro read legal", {31'b0, bus.csr_illegal}, 32'h0);
    drive(1'b1, 1'b0, 2'b11, 12'h320, 32'h4);
    @(negedge clk);
    chk("inhibit rc old", bus.csr_rdata, 32'h4);
    idle();

    // asynchronous reset away from any clock edge
    #2 reset = 1'b1;
    #1;
    chk("async tohost", tohost, 32'h0);
    chk("async rdata", bus.csr_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 12'hC00, 32'h0);
    @(negedge clk);
    chk("cycle after reset", bus.csr_rdata, 32'd3);
    idle();

`ifdef CSR_HPM_EN
    for (int k = 0; k < 3; k++) begin
      event_i = 4'b0001;
      stall   = (k == 1);
      @(negedge clk);
    end
    event_i = '0; stall = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 12'hC03, 32'h0);
    @(negedge clk);
    chk("event0 count", bus.csr_rdata, 32'd2);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/csr_counter_file.md
# csr_counter_file

Parametrised CSR and performance-counter block for the Riscv151 pipeline. It replaces the single `tohost` CSR register and the disabled cycle/instruction counters. It holds `tohost`, a counter-inhibit register, free-running cycle and retired-instruction counters, and optional per-event hardware performance counters. Writes arrive from the X stage. Read data is registered so it lands in WB alongside the load path.

## Interface
Parameters:
- `DWIDTH`, 32: CSR data width.
- `CNT_WIDTH`, 64: counter width; must satisfy DWIDTH ≤ CNT_WIDTH ≤ 2·DWIDTH.
- `NUM_EVT`, 4: number of event counters (hpmcounter3..3+NUM_EVT-1); range 1..29.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `csr_we`  in  1  CSR write strobe from the X stage.
- `csr_re`  in  1  CSR read strobe from the X stage.
- `csr_op`  in  2  01 write (RW), 10 set (RS), 11 clear (RC), 00 no write.
- `csr_addr`  in  12  CSR address (instr[31:20]).
- `csr_wdata`  in  DWIDTH  rs1 value or zero-extended uimm.
- `retire`  in  1  a non-bubble instruction is in WB this cycle.
- `stall`  in  1  memory stall; freezes `retire` and event counting.
- `event_i`  in  NUM_EVT  per-cycle event pulses (bit i increments hpmcounter3+i).
- `ctr_clear`  in  1  synchronous clear of all counters (MMIO store decode).
- `csr_rdata`  out  DWIDTH  registered read data.
- `csr_illegal`  out  1  registered pulse: access to an unmapped address, or a write to a read-only CSR.
- `tohost`  out  DWIDTH  current `tohost` value (drives the core `csr` output).
- `tohost_valid`  out  1  one-cycle pulse after `tohost` is written.

## Operation
- Address map:
  - 0x51E `tohost`, RW.
  - 0x320 `mcountinhibit`, RW. Bit 0 = cycle, bit 2 = instret, bit 3+i = event i. Other bits read 0.
  - 0xC00 / 0xC80 cycle low / high, RO.
  - 0xC02 / 0xC82 instret low / high, RO.
  - 0xC03+i / 0xC83+i event i low / high, RO.
- High-half addresses read bits [CNT_WIDTH-1:DWIDTH] zero-extended. When CNT_WIDTH == DWIDTH they are unmapped.
- Write value: RW gives wdata. RS gives old | wdata. RC gives old & ~wdata.
- An RS or RC with wdata == 0 performs no write: no `tohost_valid`, no illegal flag.
- A write to an RO address, or any access to an unmapped address, raises `csr_illegal` and changes no state.
- Counter increments:
  - cycle: increments every cycle unless inhibited.
  - instret: increments when retire & ~stall & ~inhibit.
  - event i: increments when event_i[i] & ~stall & ~inhibit.
- All counters wrap modulo 2^CNT_WIDTH; all-ones + 1 gives 0, with no flag.
- Priority on one edge: `ctr_clear` > increment. A clear that coincides with an increment leaves the counter at 0.
- `ctr_clear` does not affect `tohost` or `mcountinhibit`.
- A write to `mcountinhibit` takes effect from the next cycle; the increment on the same edge uses the old inhibit value.
- A simultaneous read and write to the same CSR returns the old value.
- If `csr_we` and `csr_re` are both low, `csr_rdata` holds its last value.

## Timing
- Read latency: 1 cycle. `csr_rdata` and `csr_illegal` are valid the cycle after `csr_re` or `csr_we`.
- A counter read returns the pre-edge value, i.e. before that cycle's increment.
- A `tohost` write is visible on `tohost` the cycle after `csr_we`. `tohost_valid` is high that same cycle only.
- Back-to-back writes on consecutive cycles give consecutive `tohost_valid` pulses.
- Reset values: every counter, `tohost`, `mcountinhibit`, `csr_rdata`, `csr_illegal` and `tohost_valid` are 0.
- Reset asserted mid-operation clears all state immediately, with no dependence on the clock.
- Counting resumes on the first rising edge after reset deasserts.

## Configuration
- `CSR_HPM_EN` defined: the NUM_EVT event counters and their inhibit bits are implemented.
- `CSR_HPM_EN` undefined:
  - No event-counter state is built and `event_i` is ignored.
  - 0xC03+i and 0xC83+i read 0 without raising `csr_illegal`.
  - `mcountinhibit` bits 3 and above read 0.

## Test plan
- Reset, then 10 idle cycles, then read 0xC00. `csr_rdata` = 10 one cycle later; `tohost` = 0; `tohost_valid` = 0.
- RW 0x51E with 0x1, then RS with 0x0. One `tohost_valid` pulse; `tohost` = 1; a read returns 0x1.
- CNT_WIDTH = 64: preload cycle to 0x0000_0000_FFFF_FFFF via `ctr_clear`-free force, then run 1 cycle. Read 0xC00 = 0, 0xC80 = 1.
- `retire` = 1 for 5 cycles with `stall` = 1 on 2 of them. instret = 3.
- Assert `ctr_clear` and `retire` on the same edge. instret = 0, then counting continues.
- Write 0x4 to 0x320, then drive `retire`. instret frozen. A write to 0xC02 raises `csr_illegal` with the count unchanged.
